// File: rtl/if_id_queue_if.sv
// Fetch/decode/execute side signals of the IF/ID instruction queue.
// slave: the queue itself; master: the surrounding pipeline (or a bench).
interface if_id_queue_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      if_pc;
  logic [31:0]      if_instr;
  logic [31:0]      if_b_addr;
  logic             stall;
  logic             PC_Src;
  logic [29:0]      Target_PC_Addr;
  logic             ex_redirect;
  logic [29:0]      ex_target;
  logic             id_valid;
  logic             id_ready;
  logic [31:0]      id_pc;
  logic [31:0]      id_instr;
  logic [31:0]      id_b_addr;
  logic [CNT_W-1:0] redirect_cnt;

  modport slave (
    input  if_pc, if_instr, if_b_addr, ex_redirect, ex_target, id_ready,
    output stall, PC_Src, Target_PC_Addr, id_valid, id_pc, id_instr,
           id_b_addr, redirect_cnt
  );

  modport master (
    output if_pc, if_instr, if_b_addr, ex_redirect, ex_target, id_ready,
    input  stall, PC_Src, Target_PC_Addr, id_valid, id_pc, id_instr,
           id_b_addr, redirect_cnt
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: circular buffer of {pc, instr, b_addr} between
// fetch and decode, fetch stall on full, and execute-redirect flush/forward.
module if_id_queue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          rst,
  if_id_queue_if.slave  bus
);
  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

  logic [31:0]      mem_pc    [DEPTH];
  logic [31:0]      mem_instr [DEPTH];
  logic [31:0]      mem_b     [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW:0]      count;
  logic [CNT_W-1:0] redirect_cnt;
  logic             full;
  logic             stall;
  logic             id_valid;
  logic             push;
  logic             pop;

  // Handshake, stall and redirect pass-through; redirect overrides everything
  // so fetch always loads the target and decode never sees a wrong-path word.
  always_comb begin
    full     = (count == CNT_FULL);
    stall    = full && !bus.id_ready && !bus.ex_redirect;
    id_valid = (count != '0) && !bus.ex_redirect;
    pop      = id_valid && bus.id_ready;
    push     = rst && !bus.ex_redirect && !stall;
  end

  assign bus.stall          = stall;
  assign bus.id_valid       = id_valid;
  assign bus.PC_Src         = bus.ex_redirect;
  assign bus.Target_PC_Addr = bus.ex_target;
  assign bus.id_pc          = mem_pc[head];
  assign bus.id_instr       = mem_instr[head];
  assign bus.id_b_addr      = mem_b[head];
  assign bus.redirect_cnt   = redirect_cnt;

  // Pointer and occupancy update; a redirect flushes the whole queue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.ex_redirect) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // Entry storage; written at tail on push. When full with a pop, tail equals
  // head but the head word is read combinationally before this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
        mem_b[i]     <= '0;
      end
    end else if (push) begin
      mem_pc[tail]    <= bus.if_pc;
      mem_instr[tail] <= bus.if_instr;
      mem_b[tail]     <= bus.if_b_addr;
    end
  end

  // Saturating count of clock cycles spent in redirect.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      redirect_cnt <= '0;
    else if (bus.ex_redirect && (redirect_cnt != '1))
      redirect_cnt <= redirect_cnt + 1'b1;
  end
endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=4, CNT_W=3 so saturation is reachable).
module tb_if_id_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  if_id_queue_if #(.CNT_W(3)) bus ();

  if_id_queue #(.DEPTH(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return pc ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present inputs just after a rising edge, then let combinational paths settle.
  task automatic drive(input logic [31:0] pc, input logic rdy,
                       input logic redir, input logic [29:0] tgt);
    bus.if_pc       = pc;
    bus.if_instr    = instr_of(pc);
    bus.if_b_addr   = pc + 32'h40;
    bus.id_ready    = rdy;
    bus.ex_redirect = redir;
    bus.ex_target   = tgt;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, "_valid"}, 32'(bus.id_valid), 32'd1);
    chk({tag, "_pc"},    bus.id_pc, pc);
    chk({tag, "_instr"}, bus.id_instr, instr_of(pc));
    chk({tag, "_baddr"}, bus.id_b_addr, pc + 32'h40);
  endtask

  initial begin
    // reset state, redirect pass-through while in reset
    drive(32'h0, 1'b1, 1'b1, 30'h3);
    chk("rst_valid",  32'(bus.id_valid), 32'd0);
    chk("rst_stall",  32'(bus.stall), 32'd0);
    chk("rst_pcsrc",  32'(bus.PC_Src), 32'd1);
    chk("rst_target", 32'(bus.Target_PC_Addr), 32'h3);
    chk("rst_idpc",   bus.id_pc, 32'h0);
    tick();
    chk("rst_rcnt",   32'(bus.redirect_cnt), 32'd0);
    drive(32'h0, 1'b1, 1'b0, 30'h0);
    rst = 1'b1;

    // streaming
    drive(32'h00, 1'b1, 1'b0, 30'h0);
    chk("c0_valid", 32'(bus.id_valid), 32'd0);
    chk("c0_pcsrc", 32'(bus.PC_Src), 32'd0);
    tick();
    drive(32'h04, 1'b1, 1'b0, 30'h0);
    chk_head("c1", 32'h00);
    chk("c1_stall", 32'(bus.stall), 32'd0);
    tick();
    drive(32'h08, 1'b1, 1'b0, 30'h0);
    chk_head("c2", 32'h04);
    tick();

    // fill with id_ready low: queue {08,0C,10,14}
    drive(32'h0C, 1'b0, 1'b0, 30'h0);
    chk_head("c3", 32'h08);
    tick();
    drive(32'h10, 1'b0, 1'b0, 30'h0);
    chk("c4_stall", 32'(bus.stall), 32'd0);
    tick();
    drive(32'h14, 1'b0, 1'b0, 30'h0);
    chk("c5_stall", 32'(bus.stall), 32'd0);
    tick();
    drive(32'h18, 1'b0, 1'b0, 30'h0);
    chk("c6_stall", 32'(bus.stall), 32'd1);
    tick();
    drive(32'h18, 1'b0, 1'b0, 30'h0);
    chk("c7_stall", 32'(bus.stall), 32'd1);
    chk_head("c7", 32'h08);
    tick();

    // full with simultaneous pop: push accepted, stays full
    drive(32'h18, 1'b1, 1'b0, 30'h0);
    chk("c8_stall", 32'(bus.stall), 32'd0);
    chk_head("c8", 32'h08);
    tick();
    drive(32'h1C, 1'b0, 1'b0, 30'h0);
    chk("c9_stall", 32'(bus.stall), 32'd1);
    chk_head("c9", 32'h0C);
    tick();
    drive(32'h1C, 1'b1, 1'b0, 30'h0);
    chk_head("c10", 32'h0C);
    tick();
    drive(32'h20, 1'b1, 1'b0, 30'h0);
    chk_head("c11", 32'h10);
    tick();
    drive(32'h24, 1'b1, 1'b0, 30'h0);
    chk_head("c12", 32'h14);
    tick();

    // redirect while full and stalled
    drive(32'h28, 1'b0, 1'b1, 30'h40);
    chk("c13_stall",  32'(bus.stall), 32'd0);
    chk("c13_valid",  32'(bus.id_valid), 32'd0);
    chk("c13_pcsrc",  32'(bus.PC_Src), 32'd1);
    chk("c13_target", 32'(bus.Target_PC_Addr), 32'h40);
    tick();
    drive(32'h100, 1'b0, 1'b0, 30'h0);
    chk("c14_valid", 32'(bus.id_valid), 32'd0);
    chk("c14_rcnt",  32'(bus.redirect_cnt), 32'd1);
    tick();
    drive(32'h104, 1'b0, 1'b0, 30'h0);
    chk_head("c15", 32'h100);
    tick();
    drive(32'h108, 1'b0, 1'b0, 30'h0);
    tick();

    // redirect with 3 entries and id_ready high: pop masked
    drive(32'h10C, 1'b1, 1'b1, 30'h80);
    chk("c17_valid", 32'(bus.id_valid), 32'd0);
    chk("c17_pcsrc", 32'(bus.PC_Src), 32'd1);
    tick();
    // back-to-back redirect: last target wins
    drive(32'h200, 1'b1, 1'b1, 30'hC0);
    chk("c18_valid",  32'(bus.id_valid), 32'd0);
    chk("c18_target", 32'(bus.Target_PC_Addr), 32'hC0);
    chk("c18_rcnt",   32'(bus.redirect_cnt), 32'd2);
    tick();
    drive(32'h300, 1'b1, 1'b0, 30'h0);
    chk("c19_valid", 32'(bus.id_valid), 32'd0);
    chk("c19_rcnt",  32'(bus.redirect_cnt), 32'd3);
    tick();
    drive(32'h304, 1'b1, 1'b0, 30'h0);
    chk_head("c20", 32'h300);
    tick();
    drive(32'h308, 1'b0, 1'b0, 30'h0);
    chk_head("c21", 32'h304);
    tick();
    drive(32'h30C, 1'b0, 1'b0, 30'h0);
    tick();

    // async reset between edges with 3 entries queued
    drive(32'h310, 1'b0, 1'b0, 30'h0);
    chk_head("c23", 32'h304);
    #1 rst = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.id_valid), 32'd0);
    chk("arst_stall", 32'(bus.stall), 32'd0);
    chk("arst_rcnt",  32'(bus.redirect_cnt), 32'd0);
    chk("arst_idpc",  bus.id_pc, 32'h0);
    #1 rst = 1'b1;
    chk("arst_rel_valid", 32'(bus.id_valid), 32'd0);
    tick();
    drive(32'h314, 1'b1, 1'b0, 30'h0);
    chk_head("c24", 32'h310);
    tick();

    // redirect counter saturation (CNT_W=3 -> 7)
    for (int i = 0; i < 9; i++) begin
      drive(32'h400, 1'b1, 1'b1, 30'h100);
      tick();
    end
    drive(32'h400, 1'b1, 1'b0, 30'h0);
    chk("sat_rcnt", 32'(bus.redirect_cnt), 32'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue and redirect controller at the back end of the fetch stage. Every cycle it captures the word, PC and branch target that fetch presents, buffers up to DEPTH entries, and hands them to decode over a valid/ready handshake. It drives the fetch stall when full and forwards execute-stage redirects to fetch as PC_Src/Target_PC_Addr, squashing all wrong-path entries.

## Interface
- DEPTH, 4: queue entries; power of two, ≥ 2.
- CNT_W, 16: width of the saturating redirect counter.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  one clock; reset is asynchronous and active-low.
- if_pc  in  32  PC_Addr from fetch; bits [1:0] always 0.
- if_instr  in  32  instruction word from fetch.
- if_b_addr  in  32  B_Addr_IF from fetch (PC + sext(imm16)<<2).
- stall  out  1  holds the fetch PC this cycle.
- PC_Src  out  1  selects Target_PC_Addr as next fetch PC.
- Target_PC_Addr  out  30  next fetch word address [31:2].
- ex_redirect  in  1  execute stage resolved a taken branch/jump/mispredict.
- ex_target  in  30  redirect word address [31:2].
- id_valid  out  1  head entry is presented to decode.
- id_ready  in  1  decode accepts head entry this cycle.
- id_pc  out  32  head entry PC.
- id_instr  out  32  head entry instruction.
- id_b_addr  out  32  head entry branch target.
- redirect_cnt  out  CNT_W  number of redirect cycles, saturating.

## Operation
- Storage: DEPTH-entry circular buffer of {pc, instr, b_addr}. Head/tail pointers are log2(DEPTH) bits and wrap modulo DEPTH. An occupancy counter runs 0..DEPTH (log2(DEPTH)+1 bits).
- Fetch presents a new valid entry every cycle rst is high; there is no fetch valid bit.
- push = rst && !ex_redirect && !stall; writes at tail, tail+1.
- pop = id_valid && id_ready; head+1.
- stall = (count == DEPTH) && !id_ready && !ex_redirect. Combinational; a full queue with a pop in the same cycle accepts the push, so count stays at DEPTH.
- id_valid = (count != 0) && !ex_redirect. id_pc/id_instr/id_b_addr = entry[head] (first-word fall-through). They hold their last value when id_valid = 0 and are don't-care for checking.
- Redirect: PC_Src = ex_redirect, Target_PC_Addr = ex_target (combinational pass-through). On the edge closing a redirect cycle:
  - head, tail and count go to 0;
  - the word fetch presents that cycle is dropped (wrong path);
  - any pop that cycle is masked because id_valid is forced 0.
- Priority: ex_redirect > pop/push. stall is never asserted during a redirect, so fetch always loads the target.
- redirect_cnt increments on every clock with ex_redirect = 1 and saturates at 2^CNT_W − 1.
- Reset values (asynchronous, rst = 0):
  - head = tail = count = 0;
  - id_valid = 0, stall = 0, redirect_cnt = 0;
  - stored entries are cleared to 0, so id_pc/id_instr/id_b_addr = 0.
- PC_Src and Target_PC_Addr follow ex_redirect/ex_target even during reset.

## Timing
- Latency: a word presented in cycle N with an empty queue appears on id_* with id_valid = 1 in cycle N+1.
- Throughput: one push and one pop per cycle sustained; count is unchanged on a simultaneous push and pop.
- Full: stall rises combinationally in the cycle count == DEPTH and id_ready = 0. That fetch word is not written and is re-presented next cycle because the PC is held.
- Empty: id_valid = 0. A word pushed into an empty queue is never bypassed to id_* in the same cycle.
- Redirect in cycle R: PC_Src = 1 and id_valid = 0 in R. Queue is empty in R+1. The first target-path word is presented by fetch in R+1 and reaches id_valid = 1 in R+2.
- Back-to-back redirects: each cycle flushes; the last target wins.
- Reset released mid-stream: capture starts on the first rising edge with rst = 1.

## Test plan
- Streaming: fetch PCs 0x00, 0x04, 0x08… with id_ready = 1 → id_pc = 0x00 in cycle 1, 0x04 in cycle 2; stall never asserted; count ≤ 1.
- Fill: DEPTH = 4, id_ready = 0 for 6 cycles → entries 0x00–0x0C stored; stall = 1 from cycle 4. Raising id_ready then drains 0x00, 0x04, 0x08, 0x0C, 0x10 in order with no loss or duplicate.
- Full with simultaneous pop: count = 4, id_ready = 1 → stall = 0, push accepted, count stays 4, head advances.
- Redirect: queue holds 3 entries, ex_redirect = 1 with ex_target = 0x100>>2 and id_ready = 1 → PC_Src = 1, id_valid = 0, no pop counted. Next cycle count = 0, and the cycle after that id_pc = 0x100. redirect_cnt increments by 1.
- Redirect while full and stalled: count = 4, id_ready = 0, ex_redirect = 1 → stall = 0 the same cycle, queue empty next cycle.
- Async reset mid-stream: rst low between clock edges with count = 3 → id_valid = 0, stall = 0, redirect_cnt = 0 immediately. After release, the first fetched word appears one cycle later.
